// File: rtl/mixpix_lbp_core.sv
// mixpix_lbp_core: serial 3x3 local-binary-pattern engine for the MixPix user area.
// The management SoC loads nine pixels and a mode bit over LA probes, then pulses start.
// Eight compare cycles build the raw code. Mode 1 adds eight rotate cycles that keep the
// smallest rotation, which makes the code rotation-invariant. Code, status and a
// completed-operation counter are returned on la_data_out.
module mixpix_lbp_core #(
    parameter int PIX_W = 8,
    parameter int CNT_W = 16
) (
    input  logic         clock,
    input  logic         resetb,
    input  logic [127:0] la_data_in,
    input  logic [127:0] la_oenb,
    output logic [127:0] la_data_out
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COMPARE = 2'd1;
    localparam logic [1:0] S_ROTATE  = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    // Index 8 is the extra commit cycle at the end of COMPARE (mode 0) or ROTATE (mode 1).
    localparam logic [3:0] IDX_LAST = 4'd7;
    localparam logic [3:0] IDX_FIN  = 4'd8;

    // Pixel number (0..8) used for code bit i; clockwise from top-left, P4 is the centre.
    function automatic logic [3:0] nbr_sel(input logic [2:0] i);
        case (i)
            3'd0:    nbr_sel = 4'd0;
            3'd1:    nbr_sel = 4'd1;
            3'd2:    nbr_sel = 4'd2;
            3'd3:    nbr_sel = 4'd5;
            3'd4:    nbr_sel = 4'd8;
            3'd5:    nbr_sel = 4'd7;
            3'd6:    nbr_sel = 4'd6;
            default: nbr_sel = 4'd3;
        endcase
    endfunction

    // Registered state
    logic [1:0]            state_q, state_d;
    logic                  st_q, st_d;
    logic [8:0][PIX_W-1:0] pix_q, pix_d;
    logic                  mode_q, mode_d;
    logic [3:0]            idx_q, idx_d;
    logic [7:0]            raw_q, raw_d;
    logic [7:0]            rot_q, rot_d;
    logic [7:0]            min_q, min_d;
    logic [7:0]            code_q, code_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    // Combinational helpers
    logic                  st_in;
    logic                  start_ok;
    logic [PIX_W-1:0]      nbr_pix;
    logic                  cmp_bit;
    logic [7:0]            raw_full;

    // Only the start bit of la_oenb and the low 74 data bits carry meaning.
    logic unused_la;
    assign unused_la = ^{la_data_in[127:74], la_oenb[127:73], la_oenb[71:0]};

    // Start qualification, neighbour selection and the compare for the current bit
    always_comb begin
        st_in    = la_data_in[72] & ~la_oenb[72];
        start_ok = st_in & ~st_q & ((state_q == S_IDLE) || (state_q == S_DONE));
        nbr_pix  = pix_q[nbr_sel(idx_q[2:0])];
        cmp_bit  = (nbr_pix >= pix_q[4]);
        // Bits shift in from the top so the first compare lands in bit 0 after eight cycles.
        raw_full = {cmp_bit, raw_q[7:1]};
    end

    // Next-state logic for the FSM, datapath and status
    always_comb begin
        state_d = state_q;
        st_d    = st_in;
        pix_d   = pix_q;
        mode_d  = mode_q;
        idx_d   = idx_q;
        raw_d   = raw_q;
        rot_d   = rot_q;
        min_d   = min_q;
        code_d  = code_q;
        done_d  = done_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_ok) begin
                    for (int k = 0; k < 9; k++) begin
                        pix_d[k] = la_data_in[k*8 +: PIX_W];
                    end
                    mode_d  = la_data_in[73];
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    state_d = S_COMPARE;
                end
            end

            S_COMPARE: begin
                if (idx_q == IDX_FIN) begin
                    // Mode 0 commit cycle; the raw code is the result.
                    code_d  = raw_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = S_DONE;
                end else begin
                    raw_d = raw_full;
                    if (idx_q == IDX_LAST && mode_q) begin
                        // Seed the rotator with the complete code; min starts at the ceiling.
                        rot_d   = raw_full;
                        min_d   = 8'hFF;
                        idx_d   = '0;
                        state_d = S_ROTATE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end

            S_ROTATE: begin
                if (idx_q == IDX_FIN) begin
                    code_d  = min_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = S_DONE;
                end else begin
                    // rot_q holds the code rotated right by idx_q positions.
                    if (rot_q < min_q) begin
                        min_d = rot_q;
                    end
                    rot_d = {rot_q[0], rot_q[7:1]};
                    idx_d = idx_q + 1'b1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset aborts any operation in flight
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q <= S_IDLE;
            st_q    <= 1'b0;
            pix_q   <= '0;
            mode_q  <= 1'b0;
            idx_q   <= '0;
            raw_q   <= '0;
            rot_q   <= '0;
            min_q   <= '0;
            code_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            pix_q   <= pix_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            raw_q   <= raw_d;
            rot_q   <= rot_d;
            min_q   <= min_d;
            code_q  <= code_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output map: code, done, busy, counter; everything above is tied low
    always_comb begin
        la_data_out              = '0;
        la_data_out[7:0]         = code_q;
        la_data_out[8]           = done_q;
        la_data_out[9]           = busy_q;
        la_data_out[10 +: CNT_W] = cnt_q;
    end

endmodule

// File: tb/tb_mixpix_lbp_core.sv
// Testbench for mixpix_lbp_core: directed cases plus randomized neighbourhoods against
// a reference LBP model computed directly from pixel values.
module tb_mixpix_lbp_core;

    logic         clock;
    logic         resetb;
    logic [127:0] la_data_in;
    logic [127:0] la_oenb;
    logic [127:0] la_data_out;

    int n_chk;
    int n_fail;

    logic [7:0]  m_code;
    logic        m_done;
    logic [15:0] m_cnt;

    mixpix_lbp_core #(.PIX_W(8), .CNT_W(16)) dut (
        .clock      (clock),
        .resetb     (resetb),
        .la_data_in (la_data_in),
        .la_oenb    (la_oenb),
        .la_data_out(la_data_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference LBP: neighbours clockwise from top-left, optional minimum over all rotations.
    function automatic logic [7:0] ref_lbp(input logic [71:0] px, input bit mode);
        int ord [8];
        int c;
        int best;
        int v;
        ord = '{0, 1, 2, 5, 8, 7, 6, 3};
        c = 0;
        for (int i = 0; i < 8; i++) begin
            if (px[ord[i]*8 +: 8] >= px[32 +: 8]) c += (1 << i);
        end
        best = c;
        if (mode) begin
            for (int r = 1; r < 8; r++) begin
                v = ((c >> r) | (c << (8 - r))) & 255;
                if (v < best) best = v;
            end
        end
        return 8'(best);
    endfunction

    task automatic chk_status(input string tag, input logic busy_exp);
        chk({tag, "_code"}, {24'h0, la_data_out[7:0]}, {24'h0, m_code});
        chk({tag, "_done"}, {31'h0, la_data_out[8]}, {31'h0, m_done});
        chk({tag, "_busy"}, {31'h0, la_data_out[9]}, {31'h0, busy_exp});
        chk({tag, "_cnt"}, {16'h0, la_data_out[25:10]}, {16'h0, m_cnt});
    endtask

    // One operation with cycle-exact status checks. Optional pixel perturbation while busy
    // and a second start pulse during the operation, both of which must have no effect.
    task automatic run_op(input string tag, input logic [71:0] px, input bit mode,
                          input logic [7:0] exp, input bit perturb, input bit restart);
        int lat;
        lat = mode ? 17 : 9;
        @(negedge clock);
        la_data_in[71:0] = px;
        la_data_in[73]   = mode;
        la_data_in[72]   = 1'b1;
        la_oenb[72]      = 1'b0;
        @(negedge clock);
        m_done = 1'b0;
        chk_status({tag, "_acc"}, 1'b1);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clock);
            if (k < lat) begin
                chk({tag, "_busy_run"}, {31'h0, la_data_out[9]}, 32'h1);
                chk({tag, "_code_hold"}, {24'h0, la_data_out[7:0]}, {24'h0, m_code});
            end
            if (k == 1 && perturb) begin
                la_data_in[71:0] = {$urandom, $urandom, $urandom};
                la_data_in[73]   = ~mode;
            end
            if (k == 2 || (restart && k == 6)) la_data_in[72] = 1'b0;
            if (restart && k == 4) la_data_in[72] = 1'b1;
        end
        m_code = exp;
        m_done = 1'b1;
        m_cnt  = m_cnt + 16'd1;
        chk_status({tag, "_end"}, 1'b0);
        chk({tag, "_hi0"}, {31'h0, |la_data_out[127:26]}, 32'h0);
        la_data_in[72] = 1'b0;
        // Done is sticky across idle cycles.
        repeat (2) @(negedge clock);
        chk({tag, "_sticky"}, {31'h0, la_data_out[8]}, 32'h1);
    endtask

    function automatic logic [71:0] fill(input logic [7:0] v);
        logic [71:0] r;
        for (int k = 0; k < 9; k++) r[k*8 +: 8] = v;
        return r;
    endfunction

    initial begin
        logic [71:0] px;
        logic [7:0]  e;
        bit          md;
        n_chk  = 0;
        n_fail = 0;
        m_code = 8'h00;
        m_done = 1'b0;
        m_cnt  = 16'h0;
        la_data_in = '0;
        la_oenb    = '1;
        resetb     = 1'b0;
        repeat (3) @(negedge clock);
        chk_status("reset", 1'b0);
        resetb = 1'b1;
        @(negedge clock);
        chk_status("post_reset", 1'b0);

        // Flat image: every neighbour equals the centre.
        run_op("flat", fill(8'h80), 1'b0, 8'hFF, 1'b0, 1'b0);

        // Bright centre: no neighbour qualifies.
        px = fill(8'h00); px[32 +: 8] = 8'hFF;
        run_op("dark_m0", px, 1'b0, 8'h00, 1'b0, 1'b0);
        run_op("dark_m1", px, 1'b1, 8'h00, 1'b0, 1'b0);

        // Bottom-left corner arc P7,P6,P3.
        px = fill(8'h10); px[32 +: 8] = 8'h40;
        px[48 +: 8] = 8'h41; px[56 +: 8] = 8'h41; px[24 +: 8] = 8'h41;
        run_op("arc_m0", px, 1'b0, 8'hE0, 1'b0, 1'b0);
        run_op("arc_m1", px, 1'b1, 8'h07, 1'b0, 1'b0);

        // Single top neighbour, with inputs scrambled while busy.
        px = fill(8'h10); px[32 +: 8] = 8'h40; px[8 +: 8] = 8'h40;
        run_op("p1_m1", px, 1'b1, 8'h01, 1'b1, 1'b0);
        run_op("p1_m0", px, 1'b0, 8'h02, 1'b1, 1'b1);

        // Start while the input is disabled: nothing happens.
        @(negedge clock);
        la_oenb[72]    = 1'b1;
        la_data_in[72] = 1'b1;
        repeat (4) @(negedge clock);
        chk_status("gated", 1'b0);
        la_data_in[72] = 1'b0;
        la_oenb[72]    = 1'b0;

        // Randomized neighbourhoods; narrow value ranges to hit equality often.
        for (int t = 0; t < 20; t++) begin
            for (int k = 0; k < 9; k++) begin
                if (t % 2 == 0) px[k*8 +: 8] = 8'($urandom_range(8'h3E, 8'h42));
                else            px[k*8 +: 8] = 8'($urandom);
            end
            md = 1'($urandom);
            e  = ref_lbp(px, md);
            run_op("rnd", px, md, e, 1'($urandom), 1'($urandom));
        end

        // Reset in the middle of COMPARE aborts immediately.
        @(negedge clock);
        la_data_in[71:0] = fill(8'h22);
        la_data_in[73]   = 1'b0;
        la_data_in[72]   = 1'b1;
        repeat (4) @(negedge clock);
        la_data_in[72] = 1'b0;
        resetb = 1'b0;
        #1;
        m_code = 8'h00; m_done = 1'b0; m_cnt = 16'h0;
        chk_status("mid_reset", 1'b0);
        @(negedge clock);
        resetb = 1'b1;
        repeat (12) @(negedge clock);
        chk_status("after_reset_idle", 1'b0);

        px = fill(8'h30); px[32 +: 8] = 8'h31; px[64 +: 8] = 8'h90;
        run_op("after_reset", px, 1'b1, ref_lbp(px, 1'b1), 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
